// File: rtl/pipe_controller.sv
// pipe_controller: five-stage MIPS control pipeline (ID/EX, EX/MEM, MEM/WB) with RAW stall,
// redirect flush and sticky SYSCALL halt. Define FORWARD_EN to swap RAW stalls for forwarding.
module pipe_controller #(
    parameter int unsigned ALUOP_W      = 4,
    parameter int unsigned RADDR_W      = 5,
    parameter int unsigned SYSCALL_HALT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         id_op,
    input  logic [5:0]         id_func,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic               id_valid,
    input  logic               ex_redirect,
    output logic               stall,
    output logic               flush_ifid,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               ex_alu_src,
    output logic               ex_signed_ext,
    output logic               ex_beq,
    output logic               ex_bne,
    output logic               ex_jmp,
    output logic               ex_jr,
    output logic               ex_jal,
    output logic               mem_mem_write,
    output logic               mem_mem_to_reg,
    output logic               wb_reg_write,
    output logic [RADDR_W-1:0] wb_waddr,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b,
    output logic               halt
);

    localparam logic [ALUOP_W-1:0] AluSll = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] AluSrl = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] AluAdd = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] AluSub = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] AluAnd = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] AluOr  = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] AluSlt = ALUOP_W'(11);

    typedef struct packed {
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src;
        logic               signed_ext;
        logic               beq;
        logic               bne;
        logic               jmp;
        logic               jr;
        logic               jal;
        logic               mem_write;
        logic               mem_to_reg;
        logic               reg_write;
        logic               syscall;
        logic [RADDR_W-1:0] waddr;
    } idex_t;

    typedef struct packed {
        logic               mem_write;
        logic               mem_to_reg;
        logic               reg_write;
        logic               syscall;
        logic [RADDR_W-1:0] waddr;
    } exmem_t;

    typedef struct packed {
        logic               reg_write;
        logic               syscall;
        logic [RADDR_W-1:0] waddr;
    } memwb_t;

    idex_t  dec, idex_q;
    exmem_t exmem_q;
    memwb_t memwb_q;
    logic   halt_q;
    logic   use_rs, use_rt, r_arith;
    logic   rs_ex, rs_mem, rt_ex, rt_mem;
    logic   hazard, frozen, bubble;

    always_comb begin
        dec     = '0;
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        r_arith = 1'b0;
        if (id_valid) begin
            case (id_op)
                6'h00: begin
                    case (id_func)
                        6'h00:        begin dec.alu_op = AluSll; r_arith = 1'b1; end
                        6'h02:        begin dec.alu_op = AluSrl; r_arith = 1'b1; end
                        6'h20, 6'h21: begin dec.alu_op = AluAdd; r_arith = 1'b1; end
                        6'h22:        begin dec.alu_op = AluSub; r_arith = 1'b1; end
                        6'h24:        begin dec.alu_op = AluAnd; r_arith = 1'b1; end
                        6'h25:        begin dec.alu_op = AluOr;  r_arith = 1'b1; end
                        6'h2A:        begin dec.alu_op = AluSlt; r_arith = 1'b1; end
                        6'h08:        begin dec.jr = 1'b1; use_rs = 1'b1; end
                        6'h0C:        dec.syscall = 1'b1;
                        default:      ;
                    endcase
                    if (r_arith) begin
                        dec.reg_write = 1'b1;
                        dec.waddr     = id_rd;
                        use_rt        = 1'b1;
                        // Shifts take their amount from shamt, not rs.
                        use_rs        = (id_func != 6'h00) && (id_func != 6'h02);
                    end
                end
                6'h08, 6'h09: begin
                    dec.alu_op = AluAdd; dec.alu_src = 1'b1; dec.signed_ext = 1'b1;
                    dec.reg_write = 1'b1; dec.waddr = id_rt; use_rs = 1'b1;
                end
                6'h0C: begin
                    dec.alu_op = AluAnd; dec.alu_src = 1'b1;
                    dec.reg_write = 1'b1; dec.waddr = id_rt; use_rs = 1'b1;
                end
                6'h0D: begin
                    dec.alu_op = AluOr; dec.alu_src = 1'b1;
                    dec.reg_write = 1'b1; dec.waddr = id_rt; use_rs = 1'b1;
                end
                6'h23: begin
                    dec.alu_op = AluAdd; dec.alu_src = 1'b1; dec.signed_ext = 1'b1;
                    dec.mem_to_reg = 1'b1; dec.reg_write = 1'b1; dec.waddr = id_rt;
                    use_rs = 1'b1;
                end
                6'h2B: begin
                    dec.alu_op = AluAdd; dec.alu_src = 1'b1; dec.signed_ext = 1'b1;
                    dec.mem_write = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
                end
                6'h04: begin
                    dec.alu_op = AluSub; dec.signed_ext = 1'b1; dec.beq = 1'b1;
                    use_rs = 1'b1; use_rt = 1'b1;
                end
                6'h05: begin
                    dec.alu_op = AluSub; dec.signed_ext = 1'b1; dec.bne = 1'b1;
                    use_rs = 1'b1; use_rt = 1'b1;
                end
                6'h02: dec.jmp = 1'b1;
                6'h03: begin
                    dec.jmp = 1'b1; dec.jal = 1'b1;
                    dec.reg_write = 1'b1; dec.waddr = RADDR_W'(31);
                end
                default: ;
            endcase
            if (dec.waddr == '0) dec.reg_write = 1'b0;
        end
    end

    function automatic logic dep(input logic [RADDR_W-1:0] src, input logic we,
                                 input logic [RADDR_W-1:0] dst);
        return (src != '0) && we && (src == dst);
    endfunction

    assign rs_ex  = use_rs && dep(id_rs, idex_q.reg_write, idex_q.waddr);
    assign rt_ex  = use_rt && dep(id_rt, idex_q.reg_write, idex_q.waddr);
    assign rs_mem = use_rs && dep(id_rs, exmem_q.reg_write, exmem_q.waddr);
    assign rt_mem = use_rt && dep(id_rt, exmem_q.reg_write, exmem_q.waddr);

`ifdef FORWARD_EN
    logic [1:0] fwd_a_d, fwd_b_d, fwd_a_q, fwd_b_q;
    // Only a load still in EX cannot be forwarded in time.
    assign hazard  = id_valid && idex_q.mem_to_reg && (rs_ex || rt_ex);
    // Producer now in EX reaches EX/MEM as this instruction enters EX; MEM producer reaches MEM/WB.
    assign fwd_a_d = rs_ex ? 2'd1 : (rs_mem ? 2'd2 : 2'd0);
    assign fwd_b_d = rt_ex ? 2'd1 : (rt_mem ? 2'd2 : 2'd0);
    assign fwd_a   = fwd_a_q;
    assign fwd_b   = fwd_b_q;
`else
    assign hazard = id_valid && (rs_ex || rs_mem || rt_ex || rt_mem);
    assign fwd_a  = 2'd0;
    assign fwd_b  = 2'd0;
`endif

    // A syscall in MEM/WB freezes the pipe on the same edge that sets halt, so nothing behind it retires.
    assign frozen     = halt_q || ((SYSCALL_HALT != 0) && memwb_q.syscall);
    assign stall      = frozen || (hazard && !ex_redirect);
    assign flush_ifid = ex_redirect && !frozen;
    assign bubble     = hazard || ex_redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
            halt_q  <= 1'b0;
`ifdef FORWARD_EN
            fwd_a_q <= 2'd0;
            fwd_b_q <= 2'd0;
`endif
        end else if (frozen) begin
            halt_q <= 1'b1;
        end else begin
            idex_q             <= bubble ? '0 : dec;
            exmem_q.mem_write  <= idex_q.mem_write;
            exmem_q.mem_to_reg <= idex_q.mem_to_reg;
            exmem_q.reg_write  <= idex_q.reg_write;
            exmem_q.syscall    <= idex_q.syscall;
            exmem_q.waddr      <= idex_q.waddr;
            memwb_q.reg_write  <= exmem_q.reg_write;
            memwb_q.syscall    <= exmem_q.syscall;
            memwb_q.waddr      <= exmem_q.waddr;
`ifdef FORWARD_EN
            fwd_a_q <= bubble ? 2'd0 : fwd_a_d;
            fwd_b_q <= bubble ? 2'd0 : fwd_b_d;
`endif
        end
    end

    assign ex_alu_op      = idex_q.alu_op;
    assign ex_alu_src     = idex_q.alu_src;
    assign ex_signed_ext  = idex_q.signed_ext;
    assign ex_beq         = idex_q.beq;
    assign ex_bne         = idex_q.bne;
    assign ex_jmp         = idex_q.jmp;
    assign ex_jr          = idex_q.jr;
    assign ex_jal         = idex_q.jal;
    assign mem_mem_write  = exmem_q.mem_write;
    assign mem_mem_to_reg = exmem_q.mem_to_reg;
    assign wb_reg_write   = memwb_q.reg_write;
    assign wb_waddr       = memwb_q.waddr;
    assign halt           = halt_q;

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench for pipe_controller; writebacks are scored against a queue of expected
// destinations pushed whenever an instruction is expected to leave ID.
module tb_pipe_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] id_op, id_func;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_valid, ex_redirect;
    logic       stall, flush_ifid;
    logic [3:0] ex_alu_op;
    logic       ex_alu_src, ex_signed_ext, ex_beq, ex_bne, ex_jmp, ex_jr, ex_jal;
    logic       mem_mem_write, mem_mem_to_reg, wb_reg_write;
    logic [4:0] wb_waddr;
    logic [1:0] fwd_a, fwd_b;
    logic       halt;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];
    logic [4:0] exp_w;

    pipe_controller dut (
        .clk(clk), .rst(rst), .id_op(id_op), .id_func(id_func), .id_rs(id_rs),
        .id_rt(id_rt), .id_rd(id_rd), .id_valid(id_valid), .ex_redirect(ex_redirect),
        .stall(stall), .flush_ifid(flush_ifid), .ex_alu_op(ex_alu_op),
        .ex_alu_src(ex_alu_src), .ex_signed_ext(ex_signed_ext), .ex_beq(ex_beq),
        .ex_bne(ex_bne), .ex_jmp(ex_jmp), .ex_jr(ex_jr), .ex_jal(ex_jal),
        .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg),
        .wb_reg_write(wb_reg_write), .wb_waddr(wb_waddr), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .halt(halt)
    );

    always #5 clk = ~clk;

    wire [10:0] ex_bus = {ex_alu_op, ex_alu_src, ex_signed_ext, ex_beq, ex_bne,
                          ex_jmp, ex_jr, ex_jal};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [5:0] func, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic redirect);
        id_op = op; id_func = func; id_rs = rs; id_rt = rt; id_rd = rd;
        id_valid = 1'b1; ex_redirect = redirect;
        #1;
    endtask

    task automatic idle();
        id_op = '0; id_func = '0; id_rs = '0; id_rt = '0; id_rd = '0;
        id_valid = 1'b0; ex_redirect = 1'b0;
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ex"}, {21'd0, ex_bus}, 0);
        chk({tag, "_mem"}, {30'd0, mem_mem_write, mem_mem_to_reg}, 0);
        chk({tag, "_wb"}, {26'd0, wb_reg_write, wb_waddr}, 0);
        chk({tag, "_ctl"}, {29'd0, stall, flush_ifid, halt}, 0);
        chk({tag, "_fwd"}, {28'd0, fwd_a, fwd_b}, 0);
    endtask

    // Scoreboard: every observed writeback must match the oldest expected destination.
    always @(negedge clk) begin
        if (rst === 1'b0 && wb_reg_write === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL wb_unexpected observed=%0d expected=none", wb_waddr);
            end
            if (exp_q.size() != 0) begin
                exp_w = exp_q.pop_front();
                assert (wb_waddr === exp_w) else begin
                    errors++;
                    $error("FAIL wb_waddr observed=%0d expected=%0d", wb_waddr, exp_w);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle();
        step(); step();
        rst = 1'b0;
        #1;
        chk_all_zero("reset");

        // add r3,r1,r2 ; sub r4,r3,r1
        issue(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 1'b0);
        chk("raw_add_stall", stall, 0);
        exp_q.push_back(5'd3);
        step();
        chk("raw_add_ex", ex_alu_op, 5);
        issue(6'h00, 6'h22, 5'd3, 5'd1, 5'd4, 1'b0);
`ifdef FORWARD_EN
        chk("raw_fwd_nostall", stall, 0);
        exp_q.push_back(5'd4);
        step();
        chk("raw_sub_ex", ex_alu_op, 6);
        chk("raw_fwd_a", fwd_a, 1);
        chk("raw_fwd_b", fwd_b, 0);
`else
        chk("raw_stall1", stall, 1);
        step();
        chk("raw_bubble", ex_alu_op, 0);
        chk("raw_stall2", stall, 1);
        step();
        chk("raw_release", stall, 0);
        exp_q.push_back(5'd4);
        step();
        chk("raw_sub_ex", ex_alu_op, 6);
`endif
        idle();
        step(); step(); step();

        // lw r5,0(r0) ; add r6,r5,r5
        issue(6'h23, 6'h00, 5'd0, 5'd5, 5'd0, 1'b0);
        exp_q.push_back(5'd5);
        step();
        chk("lw_ex_ctl", {ex_alu_src, ex_signed_ext}, 2'b11);
        issue(6'h00, 6'h20, 5'd5, 5'd5, 5'd6, 1'b0);
        chk("lu_stall", stall, 1);
        step();
        chk("lw_mem_to_reg", mem_mem_to_reg, 1);
`ifdef FORWARD_EN
        chk("lu_release", stall, 0);
        exp_q.push_back(5'd6);
        step();
        chk("lu_add_ex", ex_alu_op, 5);
        chk("lu_fwd", {fwd_a, fwd_b}, 4'b1010);
`else
        chk("lu_stall2", stall, 1);
        step();
        chk("lu_release", stall, 0);
        exp_q.push_back(5'd6);
        step();
        chk("lu_add_ex", ex_alu_op, 5);
`endif
        idle();
        step(); step(); step();

        // add r7 ; beq r1,r2 ; add r8,r7,r7 arriving with redirect
        issue(6'h00, 6'h20, 5'd1, 5'd2, 5'd7, 1'b0);
        exp_q.push_back(5'd7);
        step();
        issue(6'h04, 6'h00, 5'd1, 5'd2, 5'd0, 1'b0);
        chk("beq_stall", stall, 0);
        step();
        chk("beq_ex", {ex_beq, ex_alu_op}, {1'b1, 4'd6});
        issue(6'h00, 6'h20, 5'd7, 5'd7, 5'd8, 1'b1);
        chk("redir_stall", stall, 0);
        chk("redir_flush", flush_ifid, 1);
        step();
        idle();
        chk("redir_bubble", {21'd0, ex_bus}, 0);
        step(); step(); step();

        // jal ; addi r0,r1,5 ; sw r2,4(r1)
        issue(6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        exp_q.push_back(5'd31);
        step();
        chk("jal_ex", {ex_jmp, ex_jal}, 2'b11);
        issue(6'h08, 6'h00, 5'd1, 5'd0, 5'd0, 1'b0);
        step();
        chk("addi_r0_ex", {ex_alu_op, ex_alu_src, ex_signed_ext}, {4'd5, 2'b11});
        issue(6'h2B, 6'h00, 5'd1, 5'd2, 5'd0, 1'b0);
        step();
        idle();
        chk("jal_wb", {wb_reg_write, wb_waddr}, {1'b1, 5'd31});
        step();
        chk("addi_r0_wb", wb_reg_write, 0);
        chk("sw_mem", {mem_mem_write, mem_mem_to_reg}, 2'b10);
        step(); step();

        // Unknown opcode decodes as a bubble
        issue(6'h3F, 6'h00, 5'd1, 5'd2, 5'd3, 1'b0);
        step();
        idle();
        chk("unknown_ex", {21'd0, ex_bus}, 0);
        step(); step(); step();

        // Reset mid-stream with lw in EX
        issue(6'h23, 6'h00, 5'd1, 5'd9, 5'd0, 1'b0);
        step();
        chk("rst_lw_ex", ex_alu_src, 1);
        rst = 1'b1;
        idle();
        step(); step();
        rst = 1'b0;
        #1;
        chk_all_zero("midreset");
        step(); step(); step();

        // syscall ; add r10 -> halt, add never retires
        issue(6'h00, 6'h0C, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        issue(6'h00, 6'h20, 5'd1, 5'd2, 5'd10, 1'b0);
        step();
        idle();
        step();
        chk("halt_pre", halt, 0);
        step();
        chk("halt_set", halt, 1);
        chk("halt_stall", stall, 1);
        for (int i = 0; i < 3; i++) begin
            issue(6'h00, 6'h20, 5'd1, 5'd2, 5'd11, 1'b1);
            chk("halt_hold_stall", stall, 1);
            chk("halt_hold", halt, 1);
            chk("halt_no_wb", wb_reg_write, 0);
            step();
        end
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
        #1;
        chk("halt_cleared", halt, 0);
        chk("halt_stall_cleared", stall, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
